// File: rtl/mant_normalizer_rounder.sv
// rtl/mant_normalizer_rounder.sv - FP32 adder tail: mantissa add, normalize, round-to-nearest-even, pack
//
// Three-stage pipeline behind a valid/ready handshake. The whole pipe advances
// together whenever the output register is empty or being drained.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid / in_ready   : upstream handshake
//   op_1_f_pr, op_2_f_pr  : aligned two's-complement mantissas, hidden bit at MW-3
//   res_sig, exp_max      : provisional sign, larger exponent (denormal counted as 1)
//   sticky_in             : OR of bits lost by the alignment shift
//   out_valid / out_ready : downstream handshake
//   res, res_zero, res_ovf: packed FP32 result, exact-zero flag, overflow flag
module mant_normalizer_rounder #(
    parameter int MW = 50,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW-1:0] op_1_f_pr,
    input  logic [MW-1:0] op_2_f_pr,
    input  logic          res_sig,
    input  logic [EW-1:0] exp_max,
    input  logic          sticky_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   res,
    output logic          res_zero,
    output logic          res_ovf
);

    localparam int SW = MW + 1;          // sum width
    localparam int HB = MW - 3;          // hidden-bit position
    localparam int NW = HB + 1;          // normalized mantissa width
    localparam int FW = 24;              // kept significand including hidden bit
    localparam int PW = $clog2(SW);      // leading-one index width
    localparam int XW = EW + 1;          // exponent with headroom for carries
    localparam logic [XW-1:0] EXP_INF = XW'((1 << EW) - 1);

    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // ---------------- S1: add and take magnitude ----------------
    logic [SW-1:0] sum;
    logic [SW-1:0] mag;
    assign sum = {op_1_f_pr[MW-1], op_1_f_pr} + {op_2_f_pr[MW-1], op_2_f_pr};
    assign mag = sum[SW-1] ? -sum : sum;

    logic          s1_valid;
    logic [SW-1:0] s1_mag;
    logic          s1_sign;
    logic [EW-1:0] s1_exp;
    logic          s1_sticky;

    // ---------------- S2: leading-one detect and normalize ----------------
    logic [PW-1:0] lead;
    always_comb begin
        lead = '0;
        for (int i = 0; i < SW; i++) begin
            if (s1_mag[i]) lead = PW'(i);
        end
    end

    logic [XW-1:0] exp9;
    logic [PW-1:0] rsh;
    logic [XW-1:0] lz;
    logic [SW-1:0] lost;
    assign exp9 = {1'b0, s1_exp};
    assign rsh  = lead - PW'(HB);
    assign lz   = XW'(HB) - XW'(lead);
    assign lost = s1_mag & ~({SW{1'b1}} << rsh);

    logic [NW-1:0] norm_d;
    logic          sticky_d;
    logic [XW-1:0] exp_d;
    logic          zero_d;
    logic [XW-1:0] shl;
    always_comb begin
        norm_d   = '0;
        sticky_d = s1_sticky;
        exp_d    = '0;
        zero_d   = (s1_mag == '0);
        shl      = '0;
        if (zero_d) begin
            norm_d = '0;
        end else if (lead > PW'(HB)) begin
            // Sum grew past the hidden bit: shift right, shifted-out bits feed sticky.
            norm_d   = NW'(s1_mag >> rsh);
            sticky_d = s1_sticky | (|lost);
            exp_d    = exp9 + XW'(rsh);
        end else if (lead == PW'(HB)) begin
            norm_d = s1_mag[NW-1:0];
            exp_d  = exp9;
        end else begin
            // Cancellation: shift left, but never below the denormal exponent.
            if (exp9 > lz) begin
                shl   = lz;
                exp_d = exp9 - lz;
            end else begin
                shl   = (s1_exp == '0) ? '0 : exp9 - XW'(1);
                exp_d = '0;
            end
            norm_d = s1_mag[NW-1:0] << shl;
        end
    end

    logic          s2_valid;
    logic [NW-1:0] s2_norm;
    logic          s2_sticky;
    logic [XW-1:0] s2_exp;
    logic          s2_sign;
    logic          s2_zero;

    // ---------------- S3: round to nearest even and pack ----------------
    logic [FW-1:0] kept;
    logic          guard;
    logic          low;
    logic          round_up;
    logic [FW:0]   rnd;
    assign kept     = s2_norm[NW-1 -: FW];
    assign guard    = s2_norm[NW-FW-1];
    assign low      = (|s2_norm[NW-FW-2:0]) | s2_sticky;
    assign round_up = guard & (low | kept[0]);
    assign rnd      = {1'b0, kept} + {{FW{1'b0}}, round_up};

    logic [FW-1:0] man;
    logic [XW-1:0] e3;
    logic [31:0]   res_d;
    logic          res_zero_d;
    logic          res_ovf_d;
    always_comb begin
        man = rnd[FW-1:0];
        e3  = s2_exp;
        if (rnd[FW]) begin
            man = rnd[FW:1];
            e3  = s2_exp + XW'(1);
        end
        // A denormal that rounds up into the hidden bit becomes the smallest normal.
        if (e3 == '0 && man[FW-1]) e3 = XW'(1);

        res_d      = {s2_sign, e3[EW-1:0], man[FW-2:0]};
        res_zero_d = 1'b0;
        res_ovf_d  = 1'b0;
        if (s2_zero) begin
            res_d      = '0;
            res_zero_d = 1'b1;
        end else if (e3 >= EXP_INF) begin
            res_d     = {s2_sign, {EW{1'b1}}, {(FW-1){1'b0}}};
            res_ovf_d = 1'b1;
        end
    end

    // ---------------- Pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            res       <= '0;
            res_zero  <= 1'b0;
            res_ovf   <= 1'b0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                res      <= res_d;
                res_zero <= res_zero_d;
                res_ovf  <= res_ovf_d;
            end
        end
    end

    // Data registers carry no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        if (advance && in_valid) begin
            s1_mag    <= mag;
            s1_sign   <= sum[SW-1] ? ~res_sig : res_sig;
            s1_exp    <= exp_max;
            s1_sticky <= sticky_in;
        end
        if (advance && s1_valid) begin
            s2_norm   <= norm_d;
            s2_sticky <= sticky_d;
            s2_exp    <= exp_d;
            s2_sign   <= zero_d ? 1'b0 : s1_sign;
            s2_zero   <= zero_d;
        end
    end

endmodule

// File: tb/tb_mant_normalizer_rounder.sv
// tb/tb_mant_normalizer_rounder.sv - self-checking bench for mant_normalizer_rounder
module tb_mant_normalizer_rounder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [49:0] op_1_f_pr;
    logic [49:0] op_2_f_pr;
    logic        res_sig;
    logic [7:0]  exp_max;
    logic        sticky_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        res_zero;
    logic        res_ovf;

    always #5 clk = ~clk;

    mant_normalizer_rounder #(.MW(50), .EW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_1_f_pr (op_1_f_pr),
        .op_2_f_pr (op_2_f_pr),
        .res_sig   (res_sig),
        .exp_max   (exp_max),
        .sticky_in (sticky_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .res_zero  (res_zero),
        .res_ovf   (res_ovf)
    );

    int          checks = 0;
    int          errors = 0;
    logic [33:0] exp_q[$];
    bit          rand_ready = 0;
    bit          last_acc = 0;
    bit          got_out = 0;
    bit          prev_stall = 0;
    logic [33:0] prev_out = '0;
    logic [33:0] seen_out = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic longint sx(input logic [49:0] x);
        return longint'({{14{x[49]}}, x});
    endfunction

    // Value model: result = |a+b| * 2^(exp_max-127-47), rounded to the FP32 grid
    // (quantum set by the leading-one exponent, or the denormal quantum), then encoded.
    // Returns {zero, ovf, res}.
    function automatic logic [33:0] model(input logic [49:0] a, input logic [49:0] b,
                                          input logic sig, input logic [7:0] em, input logic st);
        longint sum, mag, kept, rem, half;
        int     p, k, e;
        logic   s, up;
        sum = sx(a) + sx(b);
        s = sig;
        mag = sum;
        if (sum < 0) begin
            mag = -sum;
            s = ~sig;
        end
        if (mag == 0) return {2'b10, 32'h0};
        p = 0;
        for (int i = 0; i < 63; i++) if (mag[i]) p = i;
        e = int'(em) + p - 47;
        if (e >= 1) k = p - 23;
        else        k = 25 - int'(em);
        up = 1'b0;
        if (k > 0) begin
            kept = mag >>> k;
            rem  = mag - (kept <<< k);
            half = 64'sd1 <<< (k - 1);
            up   = (rem > half) || (rem == half && (st || kept[0]));
        end else begin
            kept = mag <<< (-k);
        end
        if (up) kept = kept + 1;
        if (e >= 1) begin
            if (kept == (64'sd1 <<< 24)) begin
                kept = kept >>> 1;
                e++;
            end
        end else begin
            e = (kept >= (64'sd1 <<< 23)) ? 1 : 0;
        end
        if (e >= 255) return {2'b01, s, 8'hFF, 23'h0};
        return {2'b00, s, e[7:0], kept[22:0]};
    endfunction

    function automatic logic [49:0] rnd_op();
        longint v;
        v = longint'({$urandom, $urandom}) & 64'h7FFF_FFFF_FFFF;
        v = v | (64'sd1 <<< 47);
        v = v >>> $urandom_range(0, 40);
        if ($urandom_range(0, 1) == 1) v = -v;
        return v[49:0];
    endfunction

    task automatic gen(output logic [49:0] a, output logic [49:0] b, output logic sig,
                       output logic [7:0] em, output logic st);
        longint t;
        int     r;
        a = rnd_op();
        case ($urandom_range(0, 3))
            0: b = rnd_op();
            1: begin
                t = -sx(a) + longint'($urandom_range(0, 65535)) - 32768;
                b = t[49:0];
            end
            2: b = '0;
            default: b = 50'({$urandom_range(0, 32'h3FFF_FFFF)});
        endcase
        sig = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 9);
        if (r < 6)      em = 8'($urandom_range(1, 254));
        else if (r < 8) em = 8'($urandom_range(1, 20));
        else            em = 8'($urandom_range(240, 254));
        st = 1'($urandom_range(0, 1));
    endtask

    // Sampled at the falling edge: hold check, scoreboard pop, input capture.
    task automatic monitor();
        logic [33:0] now_out;
        logic [33:0] want;
        now_out  = {res_zero, res_ovf, res};
        last_acc = 0;
        got_out  = 0;
        if (!rst_n) begin
            prev_stall = 0;
            return;
        end
        if (prev_stall) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_res", 64'(now_out), 64'(prev_out));
        end
        if (out_valid && out_ready) begin
            got_out  = 1;
            seen_out = now_out;
            if (exp_q.size() == 0) begin
                chk("spurious_output", 64'(out_valid), 64'd0);
            end else begin
                want = exp_q.pop_front();
                chk("scoreboard_res", 64'(now_out), 64'(want));
            end
        end
        if (in_valid && in_ready) begin
            last_acc = 1;
            exp_q.push_back(model(op_1_f_pr, op_2_f_pr, res_sig, exp_max, sticky_in));
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = now_out;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic apply(input logic [49:0] a, input logic [49:0] b, input logic sig,
                         input logic [7:0] em, input logic st);
        op_1_f_pr = a;
        op_2_f_pr = b;
        res_sig   = sig;
        exp_max   = em;
        sticky_in = st;
        in_valid  = 1'b1;
    endtask

    task automatic send(input logic [49:0] a, input logic [49:0] b, input logic sig,
                        input logic [7:0] em, input logic st);
        apply(a, b, sig, em, st);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (last_acc) break;
        end
        if (!last_acc) chk("send_timeout", 64'(last_acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic dir(input string name, input logic [49:0] a, input logic [49:0] b,
                       input logic sig, input logic [7:0] em, input logic st,
                       input logic [33:0] req, input bit chk_lat);
        bit found;
        found = 0;
        send(a, b, sig, em, st);
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (got_out) begin
                found = 1;
                chk(name, 64'(seen_out), 64'(req));
                if (chk_lat) chk("latency", 64'(i), 64'd3);
                break;
            end
        end
        if (!found) chk({name, "_timeout"}, 64'(got_out), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    localparam logic [49:0] ONE   = 50'h0800000000000;
    localparam logic [49:0] MONE  = 50'h3800000000000;
    localparam logic [49:0] ONEH  = 50'h0C00000000000;
    localparam logic [49:0] TIE   = 50'h0000000800000;
    localparam logic [49:0] TIE_O = 50'h0000001800000;
    localparam logic [49:0] DEN   = 50'h0010000000000;
    localparam logic [49:0] ALL1  = 50'h07FFFFFFFFFFF;

    logic [49:0] ba[4];
    logic [49:0] bb[4];
    logic        bs[4];
    logic [7:0]  be[4];
    logic        bt[4];
    int          acc;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op_1_f_pr = '0; op_2_f_pr = '0; res_sig = 1'b0; exp_max = '0; sticky_in = 1'b0;

        // Hand-computed values pinning the model.
        chk("pin_two",     64'(model(ONE, ONE, 0, 8'd127, 0)),  64'({2'b00, 32'h40000000}));
        chk("pin_zero",    64'(model(ONE, MONE, 0, 8'd127, 0)), 64'({2'b10, 32'h00000000}));
        chk("pin_half",    64'(model(ONEH, MONE, 0, 8'd127, 0)), 64'({2'b00, 32'h3F000000}));
        chk("pin_tie",     64'(model(ONE, TIE, 0, 8'd127, 0)),  64'({2'b00, 32'h3F800000}));
        chk("pin_tie_odd", 64'(model(ONE, TIE_O, 0, 8'd127, 0)), 64'({2'b00, 32'h3F800002}));
        chk("pin_ovf",     64'(model(ONE, ONE, 0, 8'd254, 0)),  64'({2'b01, 32'h7F800000}));
        chk("pin_neg",     64'(model(MONE, '0, 0, 8'd127, 0)),  64'({2'b00, 32'hBF800000}));
        chk("pin_denorm",  64'(model(DEN, '0, 0, 8'd3, 0)),     64'({2'b00, 32'h00040000}));
        chk("pin_den2nrm", 64'(model(ALL1, '0, 0, 8'd1, 0)),    64'({2'b00, 32'h00800000}));

        tick();
        tick();
        rst_n = 1'b1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_res",       64'(res),       64'd0);
        chk("reset_res_zero",  64'(res_zero),  64'd0);
        chk("reset_res_ovf",   64'(res_ovf),   64'd0);
        chk("reset_in_ready",  64'(in_ready),  64'd1);

        dir("dut_two",     ONE,  ONE,   0, 8'd127, 0, {2'b00, 32'h40000000}, 1);
        dir("dut_zero",    ONE,  MONE,  0, 8'd127, 0, {2'b10, 32'h00000000}, 0);
        dir("dut_half",    ONEH, MONE,  0, 8'd127, 0, {2'b00, 32'h3F000000}, 0);
        dir("dut_tie",     ONE,  TIE,   0, 8'd127, 0, {2'b00, 32'h3F800000}, 0);
        dir("dut_tie_odd", ONE,  TIE_O, 0, 8'd127, 0, {2'b00, 32'h3F800002}, 0);
        dir("dut_ovf",     ONE,  ONE,   0, 8'd254, 0, {2'b01, 32'h7F800000}, 0);
        dir("dut_neg",     MONE, '0,    0, 8'd127, 0, {2'b00, 32'hBF800000}, 0);
        dir("dut_denorm",  DEN,  '0,    0, 8'd3,   0, {2'b00, 32'h00040000}, 0);
        dir("dut_den2nrm", ALL1, '0,    0, 8'd1,   0, {2'b00, 32'h00800000}, 0);

        // Backpressure: four back-to-back offers with the output stalled for five cycles.
        for (int i = 0; i < 4; i++) gen(ba[i], bb[i], bs[i], be[i], bt[i]);
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            apply(ba[acc], bb[acc], bs[acc], be[acc], bt[acc]);
            tick();
            if (last_acc) acc++;
        end
        chk("bp_accepted", 64'(acc), 64'd3);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && acc < 4; c++) begin
            apply(ba[acc], bb[acc], bs[acc], be[acc], bt[acc]);
            tick();
            if (last_acc) acc++;
        end
        in_valid = 1'b0;
        chk("bp_all_accepted", 64'(acc), 64'd4);
        drain();

        // Reset while the pipe is full.
        for (int i = 0; i < 3; i++) begin
            gen(ba[0], bb[0], bs[0], be[0], bt[0]);
            send(ba[0], bb[0], bs[0], be[0], bt[0]);
        end
        rst_n = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_res", 64'(res), 64'd0);
        exp_q.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_reset_idle", 64'(out_valid), 64'd0);
        end

        // Randomized traffic with random output backpressure.
        rand_ready = 1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) tick();
            gen(ba[0], bb[0], bs[0], be[0], bt[0]);
            send(ba[0], bb[0], bs[0], be[0], bt[0]);
        end
        rand_ready = 0;
        out_ready = 1'b1;
        drain();
        for (int i = 0; i < 3; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mant_normalizer_rounder.md
Name: mant_normalizer_rounder

Overview:
- Downstream neighbour of the mantissa preparer in the FP32 adder datapath.
- Consumes the two aligned 50-bit two's-complement mantissas, the result sign and the larger exponent.
- Adds the mantissas, takes the magnitude, normalizes with a leading-zero count, rounds to nearest-even and packs the IEEE-754 single result.
- Three-stage pipeline with valid/ready handshake on both sides.

Parameters:
- MW, 50, width of each prepared mantissa input.
- EW, 8, exponent width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  input operands valid.
- in_ready  output  1  block accepts an operand set this cycle.
- op_1_f_pr  input  50  prepared mantissa 1, two's complement; hidden-bit weight at bit 47.
- op_2_f_pr  input  50  prepared mantissa 2, same format.
- res_sig  input  1  provisional result sign.
- exp_max  input  8  exponent of the larger operand, with a denormal operand counted as 1.
- sticky_in  input  1  OR of bits lost by the upstream alignment shift.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- res  output  32  packed FP32 result {sign, exp[7:0], frac[22:0]}.
- res_zero  output  1  result is exactly zero.
- res_ovf  output  1  result overflowed to infinity.

Behaviour:
- Reset (rst_n=0 at a clock edge): all stage valids, out_valid, res, res_zero and res_ovf go to 0. Reset mid-operation discards every in-flight item.
- Handshake:
  - advance = ~out_valid | out_ready; in_ready = advance.
  - The whole pipe shifts when advance=1 and holds every stage register when advance=0.
  - A transfer occurs when valid&ready. Bubbles are carried, not collapsed.
- Latency: 3 cycles from input transfer to out_valid with no stall. Throughput is 1 per cycle.
- S1, add and abs:
  - sum = sext51(op_1) + sext51(op_2).
  - If sum[50]=1: mag = -sum and sign = ~res_sig. Otherwise mag = sum and sign = res_sig.
  - exp_max and sticky_in are registered alongside.
- S2, normalize (p = index of the leading one of mag):
  - mag=0: zero flag set, sign forced to 0.
  - p=48: shift right 1; the bit shifted out ORs into sticky; e = exp_max+1.
  - p=47: no shift; e = exp_max.
  - p<47: lz = 47-p. If exp_max > lz: shift left by lz, e = exp_max-lz. Otherwise shift left by exp_max-1 and e = 0 (denormal).
  - Compute with a 9-bit signed exponent.
- S3, round and pack:
  - Kept mantissa m = bits[47:24] (24 bits), guard G = bit 23, S = OR(bits[22:0]) | sticky.
  - Round up iff G & (S | m[0]).
  - If the rounded m carries out to bit 24: m >>= 1 and e += 1.
  - If e = 0 and the rounded m[23] = 1: e = 1 (denormal rounds to normal).
  - If e >= 255: res = {sign, 8'hFF, 23'h0} and res_ovf = 1.
  - Zero case: res = 32'h0 and res_zero = 1.
  - Otherwise res = {sign, e[7:0], m[22:0]}.
- Outputs are registered and hold stable while out_valid=1 and out_ready=0.

Test Plan:
- op_1=op_2=50'h0800000000000, exp_max=127, res_sig=0 -> after 3 cycles res=32'h40000000, res_zero=0, res_ovf=0.
- op_1=50'h0800000000000, op_2=50'h3800000000000, exp_max=127 -> res=32'h00000000, res_zero=1.
- op_1=50'h0C00000000000, op_2=50'h3800000000000, exp_max=127 -> res=32'h3F000000 (lz=1).
- op_1=50'h0800000000000, op_2=50'h0000000800000, sticky_in=0 -> res=32'h3F800000 (tie to even). op_2=50'h0000001800000 -> res=32'h3F800002.
- op_1=op_2=50'h0800000000000, exp_max=254 -> res=32'h7F800000, res_ovf=1. op_1=50'h3800000000000, op_2=0, res_sig=0 -> res=32'hBF800000.
- Backpressure: 4 back-to-back inputs with out_ready=0 for 5 cycles -> in_ready drops after 3 accepted, res holds, all 4 results delivered in order. Assert rst_n=0 mid-stream -> out_valid=0 next cycle.
